// File: rtl/ula_rpn_pilha_param.sv
// RPN ALU with an N-entry operand stack, opcode FSM and shared sequential multiply/divide.
// Optional divider datapath enabled by defining ULA_RPN_DIV_EN.
module ula_rpn_pilha_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          entrada,
  input  logic [2:0]                 op,
  input  logic                       push,
  input  logic                       exec,
  output logic [DATA_W-1:0]          topo,
  output logic [$clog2(DEPTH+1)-1:0] nivel,
  output logic                       busy,
  output logic                       done,
  output logic [DATA_W-1:0]          resto,
  output logic                       cout,
  output logic                       ov,
  output logic                       erro,
  output logic                       zero,
  output logic                       resto_led
);

  localparam int NW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int MSB = DATA_W - 1;

`ifdef ULA_RPN_DIV_EN
  localparam bit HAS_DIV = 1'b1;
`else
  localparam bit HAS_DIV = 1'b0;
`endif

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {OCIOSO, CALC, GRAVA} estado_t;

  estado_t state_reg, state_next;

  logic [DATA_W-1:0] stk [DEPTH];
  logic [NW-1:0]     level_reg;
  logic              done_reg;
  logic              cout_reg, ov_reg, erro_reg, zero_reg, resto_led_reg;
  logic [DATA_W-1:0] resto_reg;

  // Shared iteration registers: hi/lo form the double-width product or remainder/quotient pair.
  logic [DATA_W-1:0] hi_reg, lo_reg, opnd_reg;
  logic [CW-1:0]     cnt_reg;
  logic              is_div_reg;

  logic              idle, exec_acc, push_acc, full;
  logic              has_a, has_b, is_seq, operand_ok, op_err, cmd_err;
  logic [AW-1:0]     idx_a, idx_b;
  logic [DATA_W-1:0] a_val, b_val;
  logic [DATA_W:0]   sum_ext, dif_ext;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cout, alu_ov;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W-1:0] hi_step, lo_step;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] wr_data;

  assign idle = (state_reg == OCIOSO);
  // Exec is held off for the cycle done is high so done can never pulse twice in a row.
  assign exec_acc = exec && idle && !done_reg;
  assign push_acc = push && !exec && idle;
  assign full     = (level_reg == NW'(DEPTH));
  assign has_a    = (level_reg >= NW'(2));
  assign has_b    = (level_reg != '0);

  assign idx_b = AW'(level_reg - NW'(1));
  assign idx_a = AW'(level_reg - NW'(2));
  assign a_val = stk[idx_a];
  assign b_val = stk[idx_b];

  assign is_seq     = (op == OP_MUL) || (op == OP_DIV);
  assign operand_ok = (op == OP_NOT) ? has_b : has_a;
  assign op_err     = (op == OP_DIV) && (!HAS_DIV || (b_val == '0));
  assign cmd_err    = !operand_ok || op_err;

  assign sum_ext = {1'b0, a_val} + {1'b0, b_val};
  assign dif_ext = {1'b0, a_val} - {1'b0, b_val};

  always_comb begin
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ov   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res  = sum_ext[DATA_W-1:0];
        alu_cout = sum_ext[DATA_W];
        alu_ov   = (a_val[MSB] == b_val[MSB]) && (alu_res[MSB] != a_val[MSB]);
      end
      OP_SUB: begin
        alu_res  = dif_ext[DATA_W-1:0];
        alu_cout = dif_ext[DATA_W];
        alu_ov   = (a_val[MSB] != b_val[MSB]) && (alu_res[MSB] != a_val[MSB]);
      end
      OP_AND:  alu_res = a_val & b_val;
      OP_OR:   alu_res = a_val | b_val;
      OP_XOR:  alu_res = a_val ^ b_val;
      OP_NOT:  alu_res = ~b_val;
      default: alu_res = '0;
    endcase
  end

`ifdef ULA_RPN_DIV_EN
  logic [DATA_W:0] div_sh;
`endif

  always_comb begin
    mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    hi_step = mul_sum[DATA_W:1];
    lo_step = {mul_sum[0], lo_reg[DATA_W-1:1]};
`ifdef ULA_RPN_DIV_EN
    // Restoring step: remainder stays below the divisor, so hi never needs an extra bit.
    div_sh = {hi_reg, lo_reg[DATA_W-1]};
    if (is_div_reg) begin
      if (div_sh >= {1'b0, opnd_reg}) begin
        hi_step = DATA_W'(div_sh - {1'b0, opnd_reg});
        lo_step = {lo_reg[DATA_W-2:0], 1'b1};
      end else begin
        hi_step = div_sh[DATA_W-1:0];
        lo_step = {lo_reg[DATA_W-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      OCIOSO:  if (exec_acc && !cmd_err && is_seq) state_next = CALC;
      CALC:    if (cnt_reg == CW'(DATA_W - 1)) state_next = GRAVA;
      GRAVA:   state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = AW'(level_reg);
    wr_data = entrada;
    if (state_reg == GRAVA) begin
      wr_en   = 1'b1;
      wr_data = lo_reg;
    end else if (exec_acc) begin
      if (!cmd_err && !is_seq) begin
        wr_en   = 1'b1;
        wr_data = alu_res;
        wr_idx  = (op == OP_NOT) ? idx_b : idx_a;
      end
    end else if (push_acc && !full) begin
      wr_en = 1'b1;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stk
    always_ff @(posedge clock) begin
      if (wr_en && (wr_idx == AW'(gi))) stk[gi] <= wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg     <= OCIOSO;
      level_reg     <= '0;
      done_reg      <= 1'b0;
      cout_reg      <= 1'b0;
      ov_reg        <= 1'b0;
      erro_reg      <= 1'b0;
      zero_reg      <= 1'b0;
      resto_led_reg <= 1'b0;
      resto_reg     <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      opnd_reg      <= '0;
      cnt_reg       <= '0;
      is_div_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= 1'b0;
      case (state_reg)
        OCIOSO: begin
          if (exec_acc) begin
            if (cmd_err) begin
              erro_reg      <= 1'b1;
              cout_reg      <= 1'b0;
              ov_reg        <= 1'b0;
              zero_reg      <= 1'b0;
              resto_led_reg <= 1'b0;
              done_reg      <= 1'b1;
            end else if (is_seq) begin
              level_reg  <= level_reg - NW'(2);
              hi_reg     <= '0;
              lo_reg     <= (op == OP_DIV) ? a_val : b_val;
              opnd_reg   <= (op == OP_DIV) ? b_val : a_val;
              cnt_reg    <= '0;
              is_div_reg <= (op == OP_DIV);
            end else begin
              if (op != OP_NOT) level_reg <= level_reg - NW'(1);
              cout_reg      <= alu_cout;
              ov_reg        <= alu_ov;
              zero_reg      <= (alu_res == '0);
              erro_reg      <= 1'b0;
              resto_led_reg <= 1'b0;
              done_reg      <= 1'b1;
            end
          end else if (push_acc) begin
            if (!full) level_reg <= level_reg + NW'(1);
            erro_reg      <= full;
            cout_reg      <= 1'b0;
            ov_reg        <= 1'b0;
            zero_reg      <= 1'b0;
            resto_led_reg <= 1'b0;
          end
        end
        CALC: begin
          hi_reg  <= hi_step;
          lo_reg  <= lo_step;
          cnt_reg <= cnt_reg + CW'(1);
        end
        GRAVA: begin
          level_reg <= level_reg + NW'(1);
          done_reg  <= 1'b1;
          erro_reg  <= 1'b0;
          cout_reg  <= 1'b0;
          zero_reg  <= (lo_reg == '0);
          if (HAS_DIV && is_div_reg) begin
            ov_reg        <= 1'b0;
            resto_reg     <= hi_reg;
            resto_led_reg <= (hi_reg != '0);
          end else begin
            ov_reg        <= (hi_reg != '0);
            resto_led_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign topo      = has_b ? b_val : '0;
  assign nivel     = level_reg;
  assign busy      = !idle;
  assign done      = done_reg;
  assign cout      = cout_reg;
  assign ov        = ov_reg;
  assign erro      = erro_reg;
  assign zero      = zero_reg;
  assign resto     = HAS_DIV ? resto_reg : '0;
  assign resto_led = HAS_DIV ? resto_led_reg : 1'b0;

endmodule

// File: tb/tb_ula_rpn_pilha_param.sv
// Scoreboard bench for ula_rpn_pilha_param: a stack-of-ints model predicts each exec completion,
// a monitor checks every done pulse against the queued expectation.
module tb_ula_rpn_pilha_param;
  localparam int W    = 8;
  localparam int D    = 4;
  localparam int NW   = $clog2(D + 1);
  localparam int MOD  = 1 << W;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  entrada = '0;
  logic [2:0]    op = '0;
  logic          push = 1'b0, exec = 1'b0;
  logic [W-1:0]  topo, resto;
  logic [NW-1:0] nivel;
  logic          busy, done, cout, ov, erro, zero, resto_led;

  ula_rpn_pilha_param #(.DATA_W(W), .DEPTH(D)) dut (
    .clock(clock), .rst(rst), .entrada(entrada), .op(op), .push(push), .exec(exec),
    .topo(topo), .nivel(nivel), .busy(busy), .done(done), .resto(resto),
    .cout(cout), .ov(ov), .erro(erro), .zero(zero), .resto_led(resto_led)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  typedef struct {
    int cyc; int topo; int nivel; int cout; int ov; int erro; int zero; int rled; int resto;
  } exp_t;
  exp_t exp_q[$];

  int mstk[$];
  int m_cout = 0, m_ov = 0, m_erro = 0, m_zero = 0, m_rled = 0, m_resto = 0;

  function automatic int to_s(input int v);
    return (v >= (1 << (W - 1))) ? v - MOD : v;
  endfunction

  function automatic int mtop();
    return (mstk.size() > 0) ? mstk[mstk.size() - 1] : 0;
  endfunction

  function automatic int has_div();
`ifdef ULA_RPN_DIV_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  task automatic model_clear();
    mstk.delete();
    m_cout = 0; m_ov = 0; m_erro = 0; m_zero = 0; m_rled = 0; m_resto = 0;
  endtask

  task automatic model_exec(input int o, output bit seq_ok);
    int a, b, r, s;
    bit err;
    a = 0; b = 0; r = 0; s = 0;
    seq_ok = 1'b0;
    err = (mstk.size() < ((o == 7) ? 1 : 2));
    if (!err && o == 3) err = (has_div() == 0) || (mstk[mstk.size() - 1] == 0);
    if (err) begin
      m_erro = 1; m_cout = 0; m_ov = 0; m_zero = 0; m_rled = 0;
      return;
    end
    b = mstk.pop_back();
    if (o != 7) a = mstk.pop_back();
    m_cout = 0; m_ov = 0; m_rled = 0; m_erro = 0;
    case (o)
      0: begin
        r = a + b; m_cout = (r >= MOD); r = r % MOD;
        s = to_s(a) + to_s(b); m_ov = (s > SMAX) || (s < SMIN);
      end
      1: begin
        r = (a - b + MOD) % MOD; m_cout = (a < b);
        s = to_s(a) - to_s(b); m_ov = (s > SMAX) || (s < SMIN);
      end
      2: begin r = a * b; m_ov = (r >= MOD); r = r % MOD; seq_ok = 1'b1; end
      3: begin r = a / b; m_resto = a % b; m_rled = (m_resto != 0); seq_ok = 1'b1; end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      default: r = (~b) & (MOD - 1);
    endcase
    m_zero = (r == 0);
    mstk.push_back(r);
  endtask

  task automatic do_exec(input int o, input bit with_push, input bit wait_done);
    exp_t e;
    bit seq, got;
    int nb;
    nb = 0; got = 1'b0;
    @(negedge clock);
    model_exec(o, seq);
    e.cyc = cyc + 1 + (seq ? W + 1 : 0);
    e.topo = mtop(); e.nivel = mstk.size();
    e.cout = m_cout; e.ov = m_ov; e.erro = m_erro; e.zero = m_zero;
    e.rled = m_rled; e.resto = m_resto;
    exp_q.push_back(e);
    op = o[2:0];
    exec = 1'b1;
    if (with_push) begin
      push = 1'b1;
      entrada = W'($urandom_range(0, MOD - 1));
    end
    $display("exec op=%0d push=%0d -> expect topo=%0d nivel=%0d erro=%0d", o, with_push, e.topo, e.nivel, e.erro);
    if (!wait_done) begin
      @(negedge clock);
      exec = 1'b0; push = 1'b0;
      return;
    end
    for (int i = 0; i < 4 * W + 8; i++) begin
      @(negedge clock);
      exec = 1'b0; push = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) nb++;
    end
    chk("exec_done_seen", got, 1);
    chk("busy_cycles", nb, seq ? W + 1 : 0);
  endtask

  task automatic do_push(input int v);
    @(negedge clock);
    entrada = W'(v);
    push = 1'b1;
    if (mstk.size() == D) m_erro = 1;
    else begin
      mstk.push_back(v);
      m_erro = 0;
    end
    m_cout = 0; m_ov = 0; m_zero = 0; m_rled = 0;
    $display("push %0d -> expect topo=%0d nivel=%0d erro=%0d", v, mtop(), mstk.size(), m_erro);
    @(negedge clock);
    push = 1'b0;
    chk("push_topo", topo, mtop());
    chk("push_nivel", nivel, mstk.size());
    chk("push_erro", erro, m_erro);
    chk("push_no_done", done, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    repeat (2) @(negedge clock);
    rst = 1'b0;
    $display("reset");
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  bit prev_done = 1'b0;
  always @(negedge clock) begin
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (done) begin
        chk("done_not_consecutive", prev_done, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no pending exec (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("res_topo", topo, e.topo);
          chk("res_nivel", nivel, e.nivel);
          chk("res_cout", cout, e.cout);
          chk("res_ov", ov, e.ov);
          chk("res_erro", erro, e.erro);
          chk("res_zero", zero, e.zero);
          chk("res_resto_led", resto_led, e.rled);
          chk("res_resto", resto, e.resto);
        end
      end
      prev_done = done;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    do_reset();
    @(negedge clock);
    chk("rst_topo", topo, 0);
    chk("rst_nivel", nivel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {cout, ov, erro, zero, resto_led}, 0);
    chk("rst_resto", resto, 0);

    // 200 + 100 = 300 -> 44 with carry, no signed overflow
    do_push(200); do_push(100); do_exec(0, 0, 1);
    // 20 * 13 = 260 -> 4 with overflow
    do_push(20); do_push(13); do_exec(2, 0, 1);

    do_reset();
    do_push(47); do_push(5); do_exec(3, 0, 1);
    do_push(0); do_exec(3, 0, 1);

    // Stack limits
    do_reset();
    for (int i = 1; i <= 5; i++) do_push(i * 11);
    for (int i = 0; i < 4; i++) do_exec(0, 0, 1);
    do_exec(7, 0, 1);
    do_push(3);
    do_exec(1, 1, 1);

    // Reset in the middle of a multiply
    do_reset();
    do_push(20); do_push(13); do_exec(2, 0, 0);
    repeat (3) @(negedge clock);
    rst = 1'b1;
    exp_q.delete();
    model_clear();
    @(negedge clock);
    rst = 1'b0;
    chk("midcalc_rst_nivel", nivel, 0);
    chk("midcalc_rst_busy", busy, 0);
    chk("midcalc_rst_topo", topo, 0);
    nd = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clock);
      if (done) nd++;
    end
    chk("midcalc_no_done", nd, 0);

    // Randomized command stream
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) do_push(($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, MOD - 1));
      else do_exec($urandom_range(0, 7), r == 9, 1);
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ula_rpn_pilha_param.md
# ula_rpn_pilha_param

Parametrised successor to the 8-bit RPN ALU. It combines an N-entry operand stack, an opcode-driven execution FSM and shared sequential multiply/divide units into one block. The block sits between the debounced front-panel controls (push/exec pulses) and the display/flag LEDs. Unlike the fixed two-register design, it keeps a real stack of configurable depth, so chained RPN expressions need no re-entry.

## Interface
- DATA_W, 8, operand/result width in bits (≥4)
- DEPTH, 4, stack entries (≥2)
- clock  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- entrada  in  DATA_W  operand pushed on `push`
- op  in  3  opcode sampled on `exec`
- push  in  1  one-cycle pulse: push `entrada`
- exec  in  1  one-cycle pulse: pop B (top), pop A (next), push f(A,B)
- topo  out  DATA_W  current top of stack, 0 when empty
- nivel  out  $clog2(DEPTH+1)  number of valid entries
- busy  out  1  sequential op in progress
- done  out  1  one-cycle pulse when an exec completes (success or error)
- resto  out  DATA_W  remainder of last division
- cout, ov, erro, zero, resto_led  out  1 each  registered flags of last completed command

## Operation
- Opcodes: 000 A+B, 001 A−B, 010 A×B (sequential), 011 A÷B (sequential), 100 A&B, 101 A|B, 110 A^B, 111 ~B (unary, pops only B).
- FSM states: OCIOSO, CALC, GRAVA. OCIOSO→CALC on exec with op 010/011 and operands available; CALC→GRAVA after DATA_W iterations; GRAVA→OCIOSO writes result, pulses done. Combinational ops go OCIOSO→OCIOSO, writing the result on the exec edge.
- Multiply: unsigned shift-add over DATA_W cycles. Result is the low DATA_W bits. ov=1 if the high half is non-zero.
- Divide: unsigned restoring division over DATA_W cycles. Quotient is pushed and the remainder is latched into `resto`. resto_led=1 iff remainder≠0.
- Flags:
  - add: cout = carry-out; ov = signed overflow.
  - sub: cout = borrow (A<B unsigned); ov = signed overflow.
  - zero = result==0 for every successful op.
  - cout/ov are 0 for logic ops.
- Errors: erro=1, stack unchanged, done pulses, other flags 0.
  - exec with nivel<2 (nivel<1 for 111);
  - push with nivel==DEPTH (push discarded, no done);
  - divide by B==0 (detected at exec, no CALC entry).
- Flag hold: flags hold until the next accepted push (clears all to 0) or the next completed exec.
- Simultaneous push and exec: exec wins, push dropped silently.
- push/exec while busy: ignored silently, no flag change.
- Operands for CALC are captured at exec. The stack pops at exec and pushes at GRAVA, so nivel is temporarily reduced by 2 during CALC.

## Timing
- Reset: stack empty, nivel=0, topo=0, resto=0, all flags 0, busy=0, done=0, FSM=OCIOSO.
- push at edge N: topo/nivel updated after edge N.
- Combinational exec at edge N: result on topo, flags valid, done=1 in cycle N+1.
- Multiply/divide exec at edge N:
  - busy=1 in cycles N+1..N+DATA_W+1;
  - result on topo, flags updated, done=1 in cycle N+DATA_W+2;
  - busy=0 in the same cycle as done.
- rst during CALC aborts immediately. There is no done pulse and everything returns to reset values.
- done is never asserted for two consecutive cycles.

## Configuration
- ULA_RPN_DIV_EN defined: divider datapath present; opcode 011 behaves as above.
- ULA_RPN_DIV_EN undefined: no divider logic.
  - Opcode 011 is an error (erro=1, done pulse, stack unchanged).
  - `resto` and resto_led are tied to 0.

## Test plan
- Combinational ops: DATA_W=8. Push 200, push 100, exec 000 → topo=44, cout=1, ov=0, nivel=1, done one cycle after exec.
- Multiply: push 20, push 13, exec 010 → busy 9 cycles, then topo=4, ov=1, done at cycle N+10.
- Divide (ULA_RPN_DIV_EN): push 47, push 5, exec 011 → topo=9, resto=2, resto_led=1. Then push 0, exec 011 → erro=1, topo=0, nivel=2.
- Stack limits: DEPTH=4. Push 5 values → 5th sets erro, nivel=4. Then 3 exec 000 → nivel=1. A 4th exec → erro, stack unchanged.
- Reset: rst asserted mid-CALC of multiply → next cycle nivel=0, busy=0, no done. Simultaneous push+exec → exec result only.
